// File: rtl/snake_pkg.sv
// Shared types and constants for the snake direction controller.
package snake_pkg;

    localparam int unsigned DIR_W   = 2;
    localparam int unsigned NUM_BTN = 4;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam dir_t DIR_RESET = DIR_RIGHT;

    // Opposite heading: the encoding places opposites two apart.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchronizer, counter debouncer, rising-edge press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronize, count disagreement cycles, flip level and pulse on a debounced rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            press  <= 1'b0;
            if (sync_q[1] != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                    press   <= sync_q[1];
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake heading controller: debounced button presses become a pending
// request that is applied on the game tick.
// Build option: define SNAKE_REVERSE_BLOCK_EN to reject 180-degree reversals.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned      DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [DIR_W-1:0] RESET_DIR       = DIR_RESET
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             update_clk,
    input  logic             btn_up,
    input  logic             btn_right,
    input  logic             btn_down,
    input  logic             btn_left,
    output logic [DIR_W-1:0] dir,
    output logic             step,
    output logic             dir_changed
);

    logic [NUM_BTN-1:0] btn_vec;
    logic [NUM_BTN-1:0] press_vec;
    logic               req_vld_c;
    dir_t               req_dir_c;
    logic               accept_c;
    dir_t               dir_q;
    dir_t               pend_dir_q;
    logic               pend_vld_q;

    // Bit index equals the heading code.
    assign btn_vec = {btn_left, btn_down, btn_right, btn_up};
    assign dir     = DIR_W'(dir_q);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .btn  (btn_vec[i]),
            .press(press_vec[i])
        );
    end

    // Priority-encode same-cycle presses: UP > RIGHT > DOWN > LEFT.
    always_comb begin
        req_vld_c = |press_vec;
        req_dir_c = DIR_LEFT;
        if (press_vec[0])      req_dir_c = DIR_UP;
        else if (press_vec[1]) req_dir_c = DIR_RIGHT;
        else if (press_vec[2]) req_dir_c = DIR_DOWN;
    end

    // Decide whether the pending request may be applied on a tick.
    always_comb begin
`ifdef SNAKE_REVERSE_BLOCK_EN
        accept_c = (pend_dir_q != opposite(dir_q));
`else
        accept_c = 1'b1;
`endif
    end

    // Pending request and heading update; a press on a tick cycle survives for the next tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q       <= dir_t'(RESET_DIR);
            pend_dir_q  <= dir_t'(RESET_DIR);
            pend_vld_q  <= 1'b0;
            step        <= 1'b0;
            dir_changed <= 1'b0;
        end else begin
            step        <= update_clk;
            dir_changed <= 1'b0;
            if (update_clk) begin
                pend_vld_q <= 1'b0;
                if (pend_vld_q && accept_c) begin
                    dir_q       <= pend_dir_q;
                    dir_changed <= (pend_dir_q != dir_q);
                end
            end
            if (req_vld_c) begin
                pend_vld_q <= 1'b1;
                pend_dir_q <= req_dir_c;
            end
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: behavioural reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_snake_dir_ctrl;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       update_clk = 1'b0;
    logic       btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic [1:0] dir;
    logic       step;
    logic       dir_changed;

    int checks = 0;
    int failures = 0;

    snake_dir_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .RESET_DIR      (2'd1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .update_clk (update_clk),
        .btn_up     (btn_up),
        .btn_right  (btn_right),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .dir        (dir),
        .step       (step),
        .dir_changed(dir_changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Per button: synced stream is raw delayed two samples; the debounced level
    // follows it once it has disagreed for D consecutive samples.
    bit s1[4], s2[4], deb[4], prs[4];
    int unsigned run[4];
    int  m_dir, m_pd;
    bit  m_pv, m_step, m_chg, m_valid;

    function automatic bit accepted(input int req, input int cur);
`ifdef SNAKE_REVERSE_BLOCK_EN
        return req != (cur + 2) % 4;
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        bit raw[4];
        raw = '{btn_up, btn_right, btn_down, btn_left};
        if (reset) begin
            m_valid = 1'b1;
            m_dir = 1; m_pd = 1; m_pv = 0; m_step = 0; m_chg = 0;
            for (int b = 0; b < 4; b++) begin
                s1[b] = 0; s2[b] = 0; deb[b] = 0; prs[b] = 0; run[b] = 0;
            end
        end else begin
            m_step = update_clk;
            m_chg  = 0;
            if (update_clk) begin
                if (m_pv && accepted(m_pd, m_dir)) begin
                    m_chg = (m_pd != m_dir);
                    m_dir = m_pd;
                end
                m_pv = 0;
            end
            for (int b = 0; b < 4; b++) begin
                if (prs[b]) begin
                    m_pv = 1;
                    m_pd = b;
                    break;
                end
            end
            for (int b = 0; b < 4; b++) begin
                bit np;
                np = 0;
                if (s2[b] != deb[b]) begin
                    run[b]++;
                    if (run[b] == D) begin
                        deb[b] = s2[b];
                        run[b] = 0;
                        np = s2[b];
                    end
                end else begin
                    run[b] = 0;
                end
                prs[b] = np;
                s2[b] = s1[b];
                s1[b] = raw[b];
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_dir", int'(dir), m_dir);
            chk("model_step", int'(step), int'(m_step));
            chk("model_dir_changed", int'(dir_changed), int'(m_chg));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        update_clk = 1'b1;
        cyc(1);
        update_clk = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic chk_out(input string name, input int e_dir, input int e_step, input int e_chg);
        chk({name, "_dir"}, int'(dir), e_dir);
        chk({name, "_step"}, int'(step), e_step);
        chk({name, "_chg"}, int'(dir_changed), e_chg);
    endtask

    initial begin
        cyc(3);
        chk_out("reset", 1, 0, 0);
        reset = 1'b0;

        // Idle ticks: heading stays RIGHT.
        for (int k = 0; k < 4; k++) begin
            cyc(9);
            tick();
            chk_out("idle_tick", 1, 1, 0);
        end

        // DOWN held from release of reset, tick 20 cycles later.
        do_reset();
        btn_down = 1'b1;
        cyc(20);
        tick();
        chk_out("down_tick", 2, 1, 1);
        btn_down = 1'b0;
        cyc(10);

        // Bouncing UP settles high: exactly one request.
        for (int k = 0; k < 6; k++) begin
            btn_up = ~btn_up;
            cyc(2);
        end
        btn_up = 1'b1;
        cyc(8);
        tick();
`ifdef SNAKE_REVERSE_BLOCK_EN
        chk_out("bounce_up", 2, 1, 0);
`else
        chk_out("bounce_up", 0, 1, 1);
`endif
        btn_up = 1'b0;
        cyc(10);

        // Reversal request from RIGHT to LEFT.
        do_reset();
        btn_left = 1'b1;
        cyc(10);
        btn_left = 1'b0;
        tick();
`ifdef SNAKE_REVERSE_BLOCK_EN
        chk_out("reverse", 1, 1, 0);
`else
        chk_out("reverse", 3, 1, 1);
`endif
        cyc(10);

        // UP and LEFT in the same cycle: UP wins.
        do_reset();
        btn_up = 1'b1;
        btn_left = 1'b1;
        cyc(10);
        btn_up = 1'b0;
        btn_left = 1'b0;
        tick();
        chk_out("prio_up", 0, 1, 1);
        cyc(10);

        // RIGHT pending, then DOWN press event lands on a tick cycle.
        btn_right = 1'b1;
        cyc(10);
        btn_right = 1'b0;
        cyc(10);
        btn_down = 1'b1;
        cyc(6);
        tick();
        chk_out("old_req_on_tick", 1, 1, 1);
        cyc(4);
        tick();
        chk_out("new_req_next_tick", 2, 1, 1);
        btn_down = 1'b0;
        cyc(10);

        // Reset mid-debounce together with a tick.
        do_reset();
        btn_left = 1'b1;
        cyc(4);
        reset = 1'b1;
        update_clk = 1'b1;
        cyc(1);
        chk_out("reset_over_tick", 1, 0, 0);
        reset = 1'b0;
        update_clk = 1'b0;
        cyc(4);
        tick();
        chk_out("debounce_restart", 1, 1, 0);
        cyc(6);
        tick();
`ifdef SNAKE_REVERSE_BLOCK_EN
        chk_out("restart_left", 1, 1, 0);
`else
        chk_out("restart_left", 3, 1, 1);
`endif
        btn_left = 1'b0;
        cyc(10);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) btn_up    = ~btn_up;
            if ($urandom_range(0, 24) == 0) btn_right = ~btn_right;
            if ($urandom_range(0, 24) == 0) btn_down  = ~btn_down;
            if ($urandom_range(0, 24) == 0) btn_left  = ~btn_left;
            update_clk = ($urandom_range(0, 6) == 0);
            reset      = ($urandom_range(0, 599) == 0);
            cyc(1);
        end
        reset = 1'b0;
        update_clk = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snake_dir_ctrl.md
# snake_dir_ctrl

Direction controller for the snake game: accepts the four raw direction buttons and the periodic one-cycle `update_clk` pulse from the game-tick generator, and turns them into the snake's current heading plus a one-cycle `step` strobe. Button presses are synchronized, debounced and held as a pending request; the request is applied only on a tick, so the heading changes exactly on movement boundaries. The block sits between the board buttons and the snake body/position logic.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive `clk` cycles a synchronized button level must differ from its debounced state before the debounced state flips (10 ms at 100 MHz).
- `RESET_DIR`, 2'd1 (RIGHT): heading after reset.

- `clk`  in  1  system clock, 100 MHz
- `reset`  in  1  synchronous, active-high
- `update_clk`  in  1  one-cycle game tick from the tick generator
- `btn_up`, `btn_right`, `btn_down`, `btn_left`  in  1 each  raw asynchronous buttons, active-high
- `dir`  out  2  current heading: UP=0, RIGHT=1, DOWN=2, LEFT=3
- `step`  out  1  one-cycle strobe, the cycle after each `update_clk`
- `dir_changed`  out  1  one-cycle strobe coincident with `step` when `dir` changed on that tick

## Operation
- Each button goes through a 2-FF synchronizer, then a debouncer: counter increments while synced level ≠ debounced level, clears when equal; on reaching `DEBOUNCE_CYCLES` the debounced level takes the synced level and the counter clears.
- Rising edge of a debounced level = press event. A single press event loads `pend_dir` and sets `pend_vld`.
- Several press events in the same cycle: priority UP > RIGHT > DOWN > LEFT.
- Press events on different cycles between ticks: last one wins (overwrites `pend_dir`).
- On `update_clk`: if `pend_vld` and the request is accepted, `dir <= pend_dir`; `pend_vld` clears in every case (accepted or rejected).
- Acceptance: a request equal to `dir` is accepted (no change, `dir_changed`=0). A request for the opposite heading (`pend_dir == dir ^ 2`) is handled per Configuration.
- Press event in the same cycle as `update_clk`: the tick uses the old `pend_dir`/`pend_vld`; the new press becomes the pending request for the next tick (not cleared).
- Button releases produce no events. Holding a button produces one event only.
- Reset: `dir`=`RESET_DIR`, `step`=0, `dir_changed`=0, `pend_vld`=0, debounced levels=0, counters=0, synchronizers=0. Reset mid-debounce discards the in-progress count; reset overrides a simultaneous tick.

## Timing
- Raw press → press event: 2 (sync) + `DEBOUNCE_CYCLES` cycles; `pend_vld` high 1 cycle later.
- `update_clk` high in cycle T → `dir` updated and `step` (and `dir_changed` if applicable) high in cycle T+1, for exactly one cycle. `dir` is stable whenever `step` is high.
- Back-to-back `update_clk` pulses each produce one `step`; no minimum tick spacing.
- Debounce counter width = $clog2(`DEBOUNCE_CYCLES`+1); no wrap is possible.

## Configuration
- `SNAKE_REVERSE_BLOCK_EN` defined: a pending request opposite to `dir` is rejected on the tick (`dir` unchanged, `dir_changed`=0, `pend_vld` cleared).
- Undefined: opposite requests are accepted like any other (reversal allowed; used for debug/demo modes).

## Structure
- `snake_pkg`: `dir_t` 2-bit enum (UP, RIGHT, DOWN, LEFT), `opposite()` function (XOR 2), `DIR_RESET` constant.
- Sub-module `btn_debounce` (synchronizer + counter + debounced level + rising-edge pulse), instantiated four times; priority encode, pending register and tick logic in the top.

## Test plan
Run with `DEBOUNCE_CYCLES`=4.
- Reset, no buttons, `update_clk` every 10 cycles → `dir`=1 throughout, `step` 1 cycle after each tick, `dir_changed`=0.
- `btn_down` held from cycle 0; tick at cycle 20 → `pend_vld` by cycle 7; cycle 21: `dir`=2, `step`=1, `dir_changed`=1.
- `btn_up` bouncing (toggle every 2 cycles for 12 cycles, then stable high) → exactly one press event, 6 cycles after last toggle.
- `dir`=1, press LEFT then tick → with `SNAKE_REVERSE_BLOCK_EN`: `dir` stays 1, `dir_changed`=0, `pend_vld`=0; without: `dir`=3, `dir_changed`=1.
- UP and LEFT press events same cycle, then tick → `dir`=0; DOWN press event in same cycle as a tick → that tick applies old request, next tick applies DOWN (subject to reverse rule).
- `reset` asserted mid-debounce and coincident with a tick → no `step`, `dir`=1, debounce restarts from 0 after release.
